rx_line_checker: RTL and testbench

RX_LINE_CHECKER -- requirements
Module: rx_line_checker

---
 rtl/rx_line_checker.sv | 275 +++++++++++++++++++++++++++
 tb/tb_rx_line_checker.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_line_checker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rx_line_checker
//
// Receives framed image lines from a UART byte stream, validates each frame
// with an XOR checksum, buffers the payload and forwards it downstream over a
// valid/ready handshake. Frames that fail any check are dropped and counted.
//
// Frame: 0x4C header, row byte (bits 7:5 must be zero), PAYLOAD_BYTES payload
// bytes, checksum byte (XOR of row byte and all payload bytes).
//
// Ports
//   clk_in      in   sole clock, rising edge
//   reset       in   asynchronous, active-low reset
//   rx_data     in   [7:0] byte from UART receiver
//   rx_valid    in   one-cycle strobe qualifying rx_data
//   out_data    out  [7:0] payload byte to downstream
//   out_valid   out  out_data valid
//   out_ready   in   downstream accepts when out_valid && out_ready
//   out_row     out  [4:0] row index of the frame being forwarded
//   out_first   out  marks first payload byte
//   out_last    out  marks final payload byte
//   busy        out  high whenever a frame is in progress or forwarding
//   good_count  out  [7:0] frames accepted, saturating
//   bad_count   out  [7:0] frames rejected, saturating
//   err_pulse   out  one-cycle strobe per rejected frame
// ---------------------------------------------------------------------------
module rx_line_checker #(
    parameter int                         PAYLOAD_BYTES = 128,
    parameter int                         TIMEOUT_WIDTH = 16,
    parameter logic [TIMEOUT_WIDTH-1:0]   TIMEOUT_TICKS = 16'd50000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_row,
    output logic        out_first,
    output logic        out_last,
    output logic        busy,
    output logic [7:0]  good_count,
    output logic [7:0]  bad_count,
    output logic        err_pulse
);

    localparam logic [7:0]               HEADER   = 8'h4C;
    localparam int                       IDX_W    = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
    // Gap counter value at which one more silent tick means the timeout is reached.
    localparam logic [TIMEOUT_WIDTH-1:0] GAP_LAST = TIMEOUT_TICKS - TIMEOUT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_PAYLOAD,
        S_CHECK,
        S_FWD
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;

    logic [TIMEOUT_WIDTH-1:0] r_gap;
    logic [7:0]               r_acc;
    logic [IDX_W-1:0]         r_wr_idx;
    logic [IDX_W-1:0]         r_rd_idx;
    logic [7:0]               r_buf [PAYLOAD_BYTES];

    logic [7:0]               r_out_data;
    logic                     r_out_valid;
    logic                     r_out_first;
    logic                     r_out_last;
    logic [4:0]               r_row;
    logic [7:0]               r_good;
    logic [7:0]               r_bad;
    logic                     r_err;

    logic                     w_in_frame;
    logic                     w_timeout;
    logic                     w_start;
    logic                     w_row_take;
    logic                     w_row_bad;
    logic                     w_store;
    logic                     w_csum_ok;
    logic                     w_accept;
    logic                     w_reject;
    logic                     w_handshake;
    logic                     w_load;

    assign w_row_bad = (rx_data[7:5] != 3'b000);
    assign w_csum_ok = (rx_data == r_acc);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of block evaluation order.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (rx_valid && (rx_data == HEADER)) begin
                    w_next_state = S_ROW;
                end
            end
            S_ROW: begin
                if (rx_valid) begin
                    w_next_state = w_row_bad ? S_IDLE : S_PAYLOAD;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    if (r_wr_idx == LAST_IDX) begin
                        w_next_state = S_CHECK;
                    end
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    w_next_state = w_csum_ok ? S_FWD : S_IDLE;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            S_FWD: begin
                if (w_handshake && r_out_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output / control decode
    // -----------------------------------------------------------------------
    always_comb begin
        busy        = (r_state != S_IDLE);
        w_in_frame  = (r_state == S_ROW) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
        w_timeout   = w_in_frame && !rx_valid && (r_gap == GAP_LAST);
        w_start     = (r_state == S_IDLE)    && rx_valid && (rx_data == HEADER);
        w_row_take  = (r_state == S_ROW)     && rx_valid;
        w_store     = (r_state == S_PAYLOAD) && rx_valid;
        w_accept    = (r_state == S_CHECK)   && rx_valid && w_csum_ok;
        w_reject    = (w_row_take && w_row_bad)
                    || ((r_state == S_CHECK) && rx_valid && !w_csum_ok)
                    || w_timeout;
        w_handshake = r_out_valid && out_ready;
        // Refill the output register when it is empty or being consumed, but
        // never past the final byte; its handshake ends the frame instead.
        w_load      = (r_state == S_FWD)
                    && !(r_out_valid && r_out_last)
                    && (!r_out_valid || out_ready);
    end

    // -----------------------------------------------------------------------
    // Receive datapath: gap counter, checksum accumulator, indices, row
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_gap    <= '0;
            r_acc    <= '0;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_row    <= '0;
        end else begin
            // Outside a frame the counter sits at zero, so ROW always starts fresh.
            if (rx_valid || !w_in_frame) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + TIMEOUT_WIDTH'(1);
            end

            if (w_start) begin
                r_acc <= '0;
            end else if (w_row_take || w_store) begin
                r_acc <= r_acc ^ rx_data;
            end

            if (w_start) begin
                r_wr_idx <= '0;
                r_rd_idx <= '0;
            end else begin
                if (w_store) begin
                    r_wr_idx <= r_wr_idx + IDX_W'(1);
                end
                if (w_load) begin
                    r_rd_idx <= r_rd_idx + IDX_W'(1);
                end
            end

            if (w_row_take) begin
                r_row <= rx_data[4:0];
            end
        end
    end

    // NOTE: the payload buffer has no reset; every entry is written before it
    // is read in a frame, and omitting the reset lets it map onto RAM.
    always_ff @(posedge clk_in) begin
        if (w_store) begin
            r_buf[r_wr_idx] <= rx_data;
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= r_buf[r_rd_idx];
            r_out_valid <= 1'b1;
            r_out_first <= (r_rd_idx == '0);
            r_out_last  <= (r_rd_idx == LAST_IDX);
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Statistics: saturating counters and rejection strobe
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_good <= '0;
            r_bad  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept && (r_good != 8'hFF)) begin
                r_good <= r_good + 8'd1;
            end
            if (w_reject && (r_bad != 8'hFF)) begin
                r_bad <= r_bad + 8'd1;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_first  = r_out_first;
    assign out_last   = r_out_last;
    assign out_row    = r_row;
    assign good_count = r_good;
    assign bad_count  = r_bad;
    assign err_pulse  = r_err;

endmodule

// File: tb/tb_rx_line_checker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_rx_line_checker
//
// Directed bench for rx_line_checker. A frame-level model predicts, from the
// frame rules alone, whether each frame is accepted and which bytes must come
// out; a compare process checks every handshake and every stalled cycle.
// ---------------------------------------------------------------------------
module tb_rx_line_checker;

    localparam int         PB = 128;
    localparam logic [15:0] TO = 16'd300;

    logic        clk_in;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_row;
    logic        out_first;
    logic        out_last;
    logic        busy;
    logic [7:0]  good_count;
    logic [7:0]  bad_count;
    logic        err_pulse;

    rx_line_checker #(
        .PAYLOAD_BYTES (PB),
        .TIMEOUT_WIDTH (16),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_first  (out_first),
        .out_last   (out_last),
        .busy       (busy),
        .good_count (good_count),
        .bad_count  (bad_count),
        .err_pulse  (err_pulse)
    );

    typedef struct {
        logic [7:0] data;
        logic       first;
        logic       last;
        logic [4:0] row;
    } exp_t;

    int         n_total = 0;
    int         n_bad   = 0;
    exp_t       exp_q[$];
    int         exp_good = 0;
    int         exp_bad  = 0;
    int         exp_err  = 0;
    int         err_cnt  = 0;
    int         vcyc     = 0;
    int         rdy_mode = 0;
    logic [7:0] pl [PB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Downstream ready: constant high, or the repeating 1,0,0,1 pattern.
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            if (rdy_mode == 1) begin
                out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                ph++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Compare process: every handshake against the model, stall stability,
    // and single-cycle error strobes.
    initial begin
        logic       prev_stall;
        logic       prev_err;
        logic [7:0] pd;
        logic       pf;
        logic       plst;
        exp_t       e;
        prev_stall = 1'b0;
        prev_err   = 1'b0;
        pd = '0; pf = 1'b0; plst = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!reset) begin
                prev_stall = 1'b0;
                prev_err   = 1'b0;
            end else begin
                if (err_pulse) begin
                    err_cnt++;
                    check("err_single_cycle", prev_err, 1'b0);
                end
                if (prev_stall) begin
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_data",  out_data,  pd);
                    check("stall_first", out_first, pf);
                    check("stall_last",  out_last,  plst);
                end
                if (out_valid) begin
                    vcyc++;
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("spurious_output", out_valid, 1'b0);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_data",  out_data,  e.data);
                            check("out_first", out_first, e.first);
                            check("out_last",  out_last,  e.last);
                            check("out_row",   out_row,   e.row);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_err   = err_pulse;
                pd   = out_data;
                pf   = out_first;
                plst = out_last;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk_in);
        #1;
        rx_valid = 1'b0;
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    function automatic logic [7:0] csum_of(input logic [7:0] row);
        logic [7:0] x;
        x = row;
        for (int i = 0; i < PB; i++) x = x ^ pl[i];
        return x;
    endfunction

    // Sends a complete frame with a well-formed row byte; the model decides
    // acceptance from the XOR rule and queues the bytes that must appear.
    task automatic send_frame(input logic [7:0] row, input logic [7:0] csum);
        logic [7:0] x;
        x = row;
        send(8'h4C);
        send(row);
        for (int i = 0; i < PB; i++) begin
            send(pl[i]);
            x = x ^ pl[i];
        end
        if (x == csum) begin
            for (int i = 0; i < PB; i++) begin
                exp_q.push_back('{data: pl[i], first: (i == 0), last: (i == PB - 1), row: row[4:0]});
            end
            exp_good = sat_inc(exp_good);
        end else begin
            exp_bad = sat_inc(exp_bad);
            exp_err++;
        end
        send(csum);
    endtask

    task automatic wait_fwd(input string tag);
        int n;
        n = 0;
        while (((exp_q.size() != 0) || out_valid) && (n < 3000)) begin
            tick(1);
            n++;
        end
        check({tag, "_fwd_done"}, ((exp_q.size() == 0) && !out_valid), 1'b1);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic chk_counts(input string tag);
        check({tag, "_good"}, good_count, exp_good[7:0]);
        check({tag, "_bad"},  bad_count,  exp_bad[7:0]);
        check({tag, "_errs"}, err_cnt,    exp_err);
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_first", out_first, 1'b0);
        check("rst_out_last",  out_last,  1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_err",       err_pulse, 1'b0);
        check("rst_out_data",  out_data,  8'h00);
        check("rst_out_row",   out_row,   5'd0);
        check("rst_good",      good_count, 8'h00);
        check("rst_bad",       bad_count,  8'h00);
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        tick(2);

        // Good frame: row 5, payload 0..127, checksum 0x05.
        for (int i = 0; i < PB; i++) pl[i] = 8'(i);
        vcyc = 0;
        send_frame(8'h05, 8'h05);
        @(negedge clk_in);
        check("lat_n1_valid", out_valid, 1'b0);
        @(negedge clk_in);
        check("lat_n2_valid", out_valid, 1'b1);
        check("lat_n2_data",  out_data,  8'h00);
        check("lat_n2_first", out_first, 1'b1);
        check("lat_n2_row",   out_row,   5'd5);
        @(posedge clk_in);
        #1;
        wait_fwd("good1");
        check("good1_cycles", vcyc, PB);
        check("good1_count_lit", good_count, 8'd1);
        chk_counts("good1");

        // Same frame, wrong checksum.
        send_frame(8'h05, 8'h06);
        tick(3);
        check("badcs_valid", out_valid, 1'b0);
        check("badcs_busy",  busy, 1'b0);
        check("badcs_bad_lit", bad_count, 8'd1);
        check("badcs_err_lit", err_cnt, 1);
        chk_counts("badcs");

        // Backpressure with 1,0,0,1 ready; stray bytes during FWD are dropped.
        for (int i = 0; i < PB; i++) pl[i] = 8'(8'hFF - i);
        rdy_mode = 1;
        send_frame(8'h05, csum_of(8'h05));
        send(8'h4C);
        send(8'h05);
        send(8'h4C);
        wait_fwd("bp");
        rdy_mode = 0;
        tick(2);
        chk_counts("bp");

        // Timeout after 10 payload bytes.
        send(8'h4C);
        send(8'h03);
        for (int i = 0; i < 10; i++) send(8'(i));
        tick(int'(TO) - 3);
        check("to_not_early", err_cnt, exp_err);
        check("to_busy", busy, 1'b1);
        n = 0;
        while ((err_cnt == exp_err) && (n < 10)) begin
            tick(1);
            n++;
        end
        exp_bad = sat_inc(exp_bad);
        exp_err++;
        tick(1);
        check("to_idle", busy, 1'b0);
        chk_counts("timeout");
        for (int i = 0; i < PB; i++) pl[i] = 8'(i * 3 + 1);
        send_frame(8'h07, csum_of(8'h07));
        wait_fwd("after_to");
        chk_counts("after_to");

        // Bad row byte, then leading garbage before a good frame.
        send(8'h4C);
        send(8'h25);
        exp_bad = sat_inc(exp_bad);
        exp_err++;
        tick(2);
        check("row_busy", busy, 1'b0);
        chk_counts("badrow");
        send(8'hFF);
        send(8'h00);
        tick(2);
        check("garbage_busy", busy, 1'b0);
        chk_counts("garbage");
        send_frame(8'h1F, csum_of(8'h1F));
        wait_fwd("row31");
        chk_counts("row31");

        // Reset asserted while forwarding byte 40.
        for (int i = 0; i < PB; i++) pl[i] = 8'(i);
        send_frame(8'h02, csum_of(8'h02));
        n = 0;
        while (!(out_valid && out_ready && (out_data == 8'd40)) && (n < 500)) begin
            @(negedge clk_in);
            n++;
        end
        check("reached_byte40", out_data, 8'd40);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_good = 0;
        exp_bad  = 0;
        @(negedge clk_in);
        check("rstfwd_valid", out_valid, 1'b0);
        check("rstfwd_busy",  busy, 1'b0);
        check("rstfwd_err",   err_pulse, 1'b0);
        check("rstfwd_good",  good_count, 8'd0);
        check("rstfwd_bad",   bad_count, 8'd0);
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        tick(3);
        check("rstfwd_err_after", err_pulse, 1'b0);
        chk_counts("rstfwd");

        // 256 rejected frames saturate bad_count.
        for (int k = 0; k < 256; k++) begin
            send(8'h4C);
            send(8'h25);
            exp_bad = sat_inc(exp_bad);
            exp_err++;
        end
        tick(3);
        check("sat_bad_lit", bad_count, 8'hFF);
        chk_counts("sat");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
